pulse_gate: RTL and testbench

Pulse-sequence gate placed between the DDS source and the 8x upsampler in the NMR transmit chain. It takes the continuous sin/cos stream from the DDS and passes it, amplitude-scaled, only during programmed RF pulse windows. Outside those windows it forces the stream to zero. It also produces an aligned transmitter gate and sequence status for the control logic.

---
 rtl/pulse_gate.sv | 176 +++++++++++++++++
 tb/tb_pulse_gate.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pulse_gate.sv
// NMR transmit pulse-sequence gate: passes amplitude-scaled DDS sin/cos only
// inside programmed RF pulse windows and forces zero elsewhere.
module pulse_gate #(
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] pulse_len,
    input  logic [CW-1:0] delay_len,
    input  logic [15:0]   n_pulses,
    input  logic [15:0]   amp,
    input  logic [DW-1:0] sin_in,
    input  logic [DW-1:0] cos_in,
    input  logic          input_val,
    output logic [DW-1:0] sin_out,
    output logic [DW-1:0] cos_out,
    output logic          val,
    output logic          tx_gate,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DELAY = 2'd2
    } state_t;

    localparam logic [CW-1:0] CW_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [CW-1:0] plen_r, plen_s;
    logic [CW-1:0] dlen_r, dlen_s;
    logic [15:0]   left_r, left_s;
    logic [15:0]   amp_r, amp_s;
    logic          done_s;

    logic signed [DW+16:0] sin_ext_s, cos_ext_s, amp_ext_s;
    logic signed [DW+16:0] sin_prod_s, cos_prod_s;
    logic [DW-1:0]         sin_scaled_s, cos_scaled_s;

    logic [DW-1:0] s1_sin_r, s1_cos_r;
    logic          s1_val_r, s1_gate_r;

    // Sequencer state and latched sequence parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CW_ZERO;
            left_r  <= 16'd0;
            plen_r  <= CW_ZERO;
            dlen_r  <= CW_ZERO;
            amp_r   <= 16'd0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            left_r  <= left_s;
            plen_r  <= plen_s;
            dlen_r  <= dlen_s;
            amp_r   <= amp_s;
            done    <= done_s;
        end
    end

    // Next-state logic; abort overrides every transition and never raises done.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        left_s  = left_r;
        plen_s  = plen_r;
        dlen_s  = dlen_r;
        amp_s   = amp_r;
        done_s  = 1'b0;
        if (abort) begin
            state_s = IDLE;
            cnt_s   = CW_ZERO;
            left_s  = 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        plen_s = pulse_len;
                        dlen_s = delay_len;
                        amp_s  = amp;
                        if ((n_pulses == 16'd0) || (pulse_len == CW_ZERO)) begin
                            done_s = 1'b1;
                        end else begin
                            state_s = PULSE;
                            cnt_s   = pulse_len - CW_ONE;
                            left_s  = n_pulses;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                PULSE: begin
                    if (cnt_r != CW_ZERO) begin
                        cnt_s = cnt_r - CW_ONE;
                    end else if (left_r == 16'd1) begin
                        state_s = IDLE;
                        left_s  = 16'd0;
                        done_s  = 1'b1;
                    end else if (dlen_r != CW_ZERO) begin
                        state_s = DELAY;
                        cnt_s   = dlen_r - CW_ONE;
                        left_s  = left_r - 16'd1;
                    end else begin
                        cnt_s  = plen_r - CW_ONE;
                        left_s = left_r - 16'd1;
                    end
                end
                DELAY: begin
                    if (cnt_r != CW_ZERO) begin
                        cnt_s = cnt_r - CW_ONE;
                    end else begin
                        state_s = PULSE;
                        cnt_s   = plen_r - CW_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CW_ZERO;
                    left_s  = 16'd0;
                end
            endcase
        end
    end

    // amp is unsigned, so it is zero-extended; the product always fits DW+17 bits.
    assign sin_ext_s    = {{17{sin_in[DW-1]}}, sin_in};
    assign cos_ext_s    = {{17{cos_in[DW-1]}}, cos_in};
    assign amp_ext_s    = {{(DW+1){1'b0}}, amp_r};
    assign sin_prod_s   = sin_ext_s * amp_ext_s;
    assign cos_prod_s   = cos_ext_s * amp_ext_s;
    assign sin_scaled_s = DW'(sin_prod_s >>> 5'd16);
    assign cos_scaled_s = DW'(cos_prod_s >>> 5'd16);

    // Stage 1: register the scaled product with the gate decision of the presenting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sin_r  <= {DW{1'b0}};
            s1_cos_r  <= {DW{1'b0}};
            s1_val_r  <= 1'b0;
            s1_gate_r <= 1'b0;
        end else begin
            s1_val_r  <= input_val;
            s1_gate_r <= (state_r == PULSE);
            s1_sin_r  <= (state_r == PULSE) ? sin_scaled_s : {DW{1'b0}};
            s1_cos_r  <= (state_r == PULSE) ? cos_scaled_s : {DW{1'b0}};
        end
    end

    // Stage 2: output register, keeps data, val and tx_gate aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_out <= {DW{1'b0}};
            cos_out <= {DW{1'b0}};
            val     <= 1'b0;
            tx_gate <= 1'b0;
        end else begin
            sin_out <= s1_sin_r;
            cos_out <= s1_cos_r;
            val     <= s1_val_r;
            tx_gate <= s1_gate_r;
        end
    end

    assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_pulse_gate.sv
// Scoreboard bench for pulse_gate: the driver queues hand-computed expected
// samples, an independent monitor checks each valid output against the queue.
module tb_pulse_gate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, input_val;
    logic [31:0] pulse_len, delay_len;
    logic [15:0] n_pulses, amp, sin_in, cos_in;
    logic [15:0] sin_out, cos_out;
    logic        val, tx_gate, busy, done;

    typedef struct {
        logic [15:0] s;
        logic [15:0] c;
        logic        g;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    pulse_gate #(.DW(16), .CW(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pulse_len(pulse_len), .delay_len(delay_len), .n_pulses(n_pulses), .amp(amp),
        .sin_in(sin_in), .cos_in(cos_in), .input_val(input_val),
        .sin_out(sin_out), .cos_out(cos_out), .val(val), .tx_gate(tx_gate),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: pops one expectation per valid output sample.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (val === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sample", {sin_out, cos_out, 7'd0, tx_gate}, {e.s, e.c, 7'd0, e.g});
                end
            end
        end
    end

    // One sequence. pat holds the hand-derived tx_gate pattern, LSB = first cycle after start.
    task automatic seq(input string nm, input logic [31:0] l, input logic [31:0] d,
                       input logic [15:0] n, input logic [15:0] a,
                       input logic [15:0] s, input logic [15:0] c,
                       input logic [15:0] es, input logic [15:0] ec,
                       input int total, input logic [31:0] pat,
                       input int abort_at, input int again_at, input bit scramble,
                       input int gapmod);
        logic g;
        @(negedge clk);
        chk({nm, "_idle_before"}, {63'd0, busy}, 64'd0);
        pulse_len = l; delay_len = d; n_pulses = n; amp = a;
        sin_in = s; cos_in = c; start = 1'b1; abort = 1'b0; input_val = 1'b1;
        sb.push_back('{16'h0000, 16'h0000, 1'b0});
        for (int t = 0; t < total + 4; t++) begin
            @(negedge clk);
            start = (t == again_at);
            abort = (t == abort_at);
            if (scramble && t == 1) begin
                pulse_len = 32'd2; delay_len = 32'd9; n_pulses = 16'd1; amp = 16'h0000;
            end
            chk({nm, "_busy"}, {63'd0, busy},
                {63'd0, (t < total) && !(abort_at >= 0 && t > abort_at)});
            chk({nm, "_done"}, {63'd0, done}, {63'd0, (t == total) && (abort_at < 0)});
            g = (t < 32) ? pat[t] : 1'b0;
            if (gapmod > 0 && (t % gapmod) == gapmod - 1) begin
                input_val = 1'b0;
            end else begin
                input_val = 1'b1;
                sb.push_back('{g ? es : 16'h0000, g ? ec : 16'h0000, g});
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; input_val = 1'b0;
        pulse_len = 32'd0; delay_len = 32'd0; n_pulses = 16'd0; amp = 16'd0;
        sin_in = 16'd0; cos_in = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", {sin_out, cos_out, 28'd0, val, tx_gate, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a pulse.
        pulse_len = 32'd20; n_pulses = 16'd1; amp = 16'h8000;
        sin_in = 16'h4000; cos_in = 16'hC000; start = 1'b1; input_val = 1'b1;
        sb.push_back('{16'h0000, 16'h0000, 1'b0});
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            sb.push_back('{16'h2000, 16'hE000, 1'b1});
        end
        chk("pre_reset_active", {62'd0, tx_gate, busy}, 64'd3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {sin_out, cos_out, 28'd0, val, tx_gate, busy, done}, 64'd0);
        sb.delete();
        input_val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", {62'd0, busy, val}, 64'd0);
        end

        seq("single", 32'd10, 32'd0, 16'd1, 16'h8000, 16'h4000, 16'hC000,
            16'h2000, 16'hE000, 10, 32'h0000_03FF, -1, -1, 1'b0, 0);
        seq("amp_max_neg", 32'd3, 32'd0, 16'd1, 16'hFFFF, 16'h8000, 16'h7FFF,
            16'h8000, 16'h7FFE, 3, 32'h0000_0007, -1, -1, 1'b0, 0);
        seq("amp_max_m1", 32'd3, 32'd0, 16'd1, 16'hFFFF, 16'hFFFF, 16'h0000,
            16'hFFFF, 16'h0000, 3, 32'h0000_0007, -1, -1, 1'b0, 0);
        seq("amp_zero", 32'd3, 32'd0, 16'd1, 16'h0000, 16'h7FFF, 16'h8000,
            16'h0000, 16'h0000, 3, 32'h0000_0007, -1, -1, 1'b0, 0);
        seq("train", 32'd4, 32'd3, 16'd3, 16'h8000, 16'h0100, 16'hFF00,
            16'h0080, 16'hFF80, 18, 32'b11_1100_0111_1000_1111, -1, -1, 1'b0, 5);
        seq("train_nodelay", 32'd4, 32'd0, 16'd3, 16'h8000, 16'h0100, 16'hFF00,
            16'h0080, 16'hFF80, 12, 32'h0000_0FFF, -1, -1, 1'b0, 0);
        seq("n_zero", 32'd5, 32'd2, 16'd0, 16'h8000, 16'h4000, 16'hC000,
            16'h2000, 16'hE000, 0, 32'h0, -1, -1, 1'b0, 0);
        seq("len_zero", 32'd0, 32'd2, 16'd4, 16'h8000, 16'h4000, 16'hC000,
            16'h2000, 16'hE000, 0, 32'h0, -1, -1, 1'b0, 0);
        seq("restart_ignored", 32'd6, 32'd0, 16'd1, 16'h8000, 16'h4000, 16'hC000,
            16'h2000, 16'hE000, 6, 32'h0000_003F, -1, 2, 1'b0, 0);
        seq("param_change", 32'd4, 32'd3, 16'd3, 16'h8000, 16'h4000, 16'hC000,
            16'h2000, 16'hE000, 18, 32'b11_1100_0111_1000_1111, -1, -1, 1'b1, 0);
        seq("abort_delay", 32'd4, 32'd3, 16'd3, 16'h8000, 16'h4000, 16'hC000,
            16'h2000, 16'hE000, 18, 32'h0000_000F, 5, -1, 1'b0, 0);

        @(negedge clk);
        input_val = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
